// File: rtl/dp_stream_deparser.sv
// dp_stream_deparser: accepts a whole packet buffer in one handshake, applies
// an optional IPv4 header-field rewrite, then replays the buffer as an
// AXI-Stream packet one beat at a time.
// Optional feature macro: DP_DEPARSER_CSUM_UPDATE_EN. When it is defined, a
// rewritten header gets its IPv4 checksum recomputed during one extra CSUM
// cycle, and hdr_checksum is ignored.
module dp_stream_deparser #(
    parameter int DATA_WIDTH     = 64,
    parameter int ID_WIDTH       = 1,
    parameter int DEST_WIDTH     = 9,
    parameter int USER_WIDTH     = 97,
    parameter int MAX_BEATS      = 8,
    parameter int BEAT_CNT_WIDTH = 4,
    localparam int KEEP_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                             clk,
    input  logic                             rst,

    input  logic                             load_valid,
    output logic                             load_ready,
    input  logic [MAX_BEATS*DATA_WIDTH-1:0]  load_tdata,
    input  logic [MAX_BEATS*KEEP_WIDTH-1:0]  load_tkeep,
    input  logic [MAX_BEATS*USER_WIDTH-1:0]  load_tuser,
    input  logic [ID_WIDTH-1:0]              load_tid,
    input  logic [DEST_WIDTH-1:0]            load_tdest,
    input  logic [BEAT_CNT_WIDTH-1:0]        load_beats,
    input  logic                             load_drop,

    input  logic                             rewrite_en,
    input  logic [5:0]                       hdr_dscp,
    input  logic [1:0]                       hdr_ecn,
    input  logic [7:0]                       hdr_ttl,
    input  logic [15:0]                      hdr_checksum,
    input  logic [31:0]                      hdr_src_ipv4,
    input  logic [31:0]                      hdr_dst_ipv4,

    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic [USER_WIDTH-1:0]            m_axis_tuser,
    output logic [ID_WIDTH-1:0]              m_axis_tid,
    output logic [DEST_WIDTH-1:0]            m_axis_tdest,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic                             m_axis_tlast,

    output logic [31:0]                      pkt_count,
    output logic [31:0]                      drop_count
);

    localparam int FLAT_W = MAX_BEATS * DATA_WIDTH;
    localparam int IDX_W  = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [BEAT_CNT_WIDTH-1:0] MAX_BEATS_C = BEAT_CNT_WIDTH'(MAX_BEATS);
    localparam logic [BEAT_CNT_WIDTH-1:0] ONE_BEAT_C  = BEAT_CNT_WIDTH'(1);
    localparam logic [IDX_W-1:0]          IDX_ONE_C   = IDX_W'(1);

`ifdef DP_DEPARSER_CSUM_UPDATE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_CSUM, ST_SEND} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_SEND} state_t;
`endif

    state_t state_q, state_d;

    // Packet buffer and per-packet metadata
    logic [FLAT_W-1:0]                 data_q;
    logic [MAX_BEATS*KEEP_WIDTH-1:0]   keep_q;
    logic [MAX_BEATS*USER_WIDTH-1:0]   user_q;
    logic [ID_WIDTH-1:0]               id_q;
    logic [DEST_WIDTH-1:0]             dest_q;
    logic [IDX_W-1:0]                  last_idx_q;
    logic [IDX_W-1:0]                  idx_q;
    logic [31:0]                       pkt_count_q;
    logic [31:0]                       drop_count_q;
`ifdef DP_DEPARSER_CSUM_UPDATE_EN
    logic [15:0]                       csum_val;
`endif

    // Control strobes from the FSM
    logic load_fire;    // any load handshake
    logic load_take;    // handshake of a packet that will be sent
    logic load_bad;     // packet must be discarded
    logic beat_fire;    // output beat transferred
    logic is_last;

    logic [FLAT_W-1:0] rw_data;

    // Unpacked views of the buffer, one entry per beat
    logic [DATA_WIDTH-1:0] beat_data [MAX_BEATS];
    logic [KEEP_WIDTH-1:0] beat_keep [MAX_BEATS];
    logic [USER_WIDTH-1:0] beat_user [MAX_BEATS];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_BEATS; gi++) begin : g_beat
            assign beat_data[gi] = data_q[gi*DATA_WIDTH +: DATA_WIDTH];
            assign beat_keep[gi] = keep_q[gi*KEEP_WIDTH +: KEEP_WIDTH];
            assign beat_user[gi] = user_q[gi*USER_WIDTH +: USER_WIDTH];
        end
    endgenerate

    assign load_bad = load_drop || (load_beats == '0) || (load_beats > MAX_BEATS_C);
    assign is_last  = (idx_q == last_idx_q);

    // Header rewrite applied on the way into the buffer; multi-byte fields are
    // big-endian, so the MSB lands on the lowest flat byte.
    always_comb begin
        rw_data = load_tdata;
        if (rewrite_en) begin
            rw_data[15*8 +: 8] = {hdr_dscp, hdr_ecn};
            rw_data[22*8 +: 8] = hdr_ttl;
            rw_data[24*8 +: 8] = hdr_checksum[15:8];
            rw_data[25*8 +: 8] = hdr_checksum[7:0];
            rw_data[26*8 +: 8] = hdr_src_ipv4[31:24];
            rw_data[27*8 +: 8] = hdr_src_ipv4[23:16];
            rw_data[28*8 +: 8] = hdr_src_ipv4[15:8];
            rw_data[29*8 +: 8] = hdr_src_ipv4[7:0];
            rw_data[30*8 +: 8] = hdr_dst_ipv4[31:24];
            rw_data[31*8 +: 8] = hdr_dst_ipv4[23:16];
            rw_data[32*8 +: 8] = hdr_dst_ipv4[15:8];
            rw_data[33*8 +: 8] = hdr_dst_ipv4[7:0];
        end
    end

`ifdef DP_DEPARSER_CSUM_UPDATE_EN
    // IPv4 header checksum over bytes 14..33, skipping the checksum word itself.
    function automatic logic [15:0] hdr_csum(input logic [FLAT_W-1:0] flat);
        logic [19:0] acc;
        acc = '0;
        for (int w = 0; w < 10; w++) begin
            if (w != 5) begin
                acc = acc + 20'({flat[(14 + 2*w)*8 +: 8], flat[(15 + 2*w)*8 +: 8]});
            end
        end
        acc = 20'(acc[15:0]) + 20'(acc[19:16]);
        acc = 20'(acc[15:0]) + 20'(acc[19:16]);
        return ~acc[15:0];
    endfunction

    assign csum_val = hdr_csum(data_q);
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and stream outputs; outputs are zero outside SEND
    always_comb begin
        state_d       = state_q;
        load_ready    = 1'b0;
        load_fire     = 1'b0;
        load_take     = 1'b0;
        beat_fire     = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tuser  = '0;
        m_axis_tid    = '0;
        m_axis_tdest  = '0;
        case (state_q)
            ST_IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    load_fire = 1'b1;
                    if (!load_bad) begin
                        load_take = 1'b1;
`ifdef DP_DEPARSER_CSUM_UPDATE_EN
                        state_d = rewrite_en ? ST_CSUM : ST_SEND;
`else
                        state_d = ST_SEND;
`endif
                    end
                end
            end
`ifdef DP_DEPARSER_CSUM_UPDATE_EN
            ST_CSUM: begin
                state_d = ST_SEND;
            end
`endif
            ST_SEND: begin
                m_axis_tvalid = 1'b1;
                m_axis_tlast  = is_last;
                m_axis_tdata  = beat_data[idx_q];
                m_axis_tkeep  = beat_keep[idx_q];
                m_axis_tuser  = beat_user[idx_q];
                m_axis_tid    = id_q;
                m_axis_tdest  = dest_q;
                if (m_axis_tready) begin
                    beat_fire = 1'b1;
                    if (is_last) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Buffer capture on an accepted load, checksum patch in CSUM
    always_ff @(posedge clk) begin
        if (load_take) begin
            data_q     <= rw_data;
            keep_q     <= load_tkeep;
            user_q     <= load_tuser;
            id_q       <= load_tid;
            dest_q     <= load_tdest;
            last_idx_q <= IDX_W'(load_beats - ONE_BEAT_C);
        end
`ifdef DP_DEPARSER_CSUM_UPDATE_EN
        else if (state_q == ST_CSUM) begin
            data_q[24*8 +: 16] <= {csum_val[7:0], csum_val[15:8]};
        end
`endif
    end

    // Beat index and packet/drop counters (counters wrap naturally)
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q        <= '0;
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            if (load_take) begin
                idx_q <= '0;
            end else if (beat_fire) begin
                idx_q <= idx_q + IDX_ONE_C;
            end
            if (load_fire && load_bad) begin
                drop_count_q <= drop_count_q + 32'd1;
            end
            if (beat_fire && is_last) begin
                pkt_count_q <= pkt_count_q + 32'd1;
            end
        end
    end

    assign pkt_count  = pkt_count_q;
    assign drop_count = drop_count_q;

endmodule
